// File: rtl/boot_mem.sv
// Dual-port 2048x32 program/data memory that also sequences the core's boot:
// optional clear (BOOT_MEM_CLEAR_EN), streamed program load, then run.
module boot_mem #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      pc,
  output logic [WIDTH-1:0] instr,
  input  logic [10:0]      ram_addr2,
  input  logic [WIDTH-1:0] ram_in2,
  input  logic             mem_w_en,
  output logic [WIDTH-1:0] ram_data2,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             load_ready,
  output logic             cpu_rst_n,
  output logic             boot_done,
  output logic             load_overflow
);

  localparam int AW = 11;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

`ifdef BOOT_MEM_CLEAR_EN
  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;
  localparam state_t INIT_STATE = CLEAR;
`else
  typedef enum logic [1:0] {LOAD, RUN} state_t;
  localparam state_t INIT_STATE = LOAD;
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  state_t           state;
  logic [AW-1:0]    ld_addr;
`ifdef BOOT_MEM_CLEAR_EN
  logic [AW-1:0]    clr_cnt;
`endif
  logic             accept;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  assign accept = (state == LOAD) && load_valid && load_ready;

  // Clear, load and CPU writes never overlap in time, so one write port serves all three.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ram_addr2;
    wr_data = ram_in2;
    if (!rst) begin
      case (state)
`ifdef BOOT_MEM_CLEAR_EN
        CLEAR: begin
          wr_en   = 1'b1;
          wr_addr = clr_cnt;
          wr_data = '0;
        end
`endif
        LOAD: begin
          wr_en   = accept;
          wr_addr = ld_addr;
          wr_data = load_data;
        end
        RUN:     wr_en = mem_w_en;
        default: wr_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Reads sample the array before this edge's write lands, giving read-first collisions.
  always_ff @(posedge clk) begin
    if (rst || state != RUN) begin
      instr     <= '0;
      ram_data2 <= '0;
    end else begin
      instr     <= mem[pc];
      ram_data2 <= mem[ram_addr2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT_STATE;
      ld_addr       <= '0;
      load_ready    <= 1'b0;
      boot_done     <= 1'b0;
      cpu_rst_n     <= 1'b0;
      load_overflow <= 1'b0;
`ifdef BOOT_MEM_CLEAR_EN
      clr_cnt       <= '0;
`endif
    end else begin
      case (state)
`ifdef BOOT_MEM_CLEAR_EN
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state      <= LOAD;
            load_ready <= 1'b1;
          end
        end
`endif
        LOAD: begin
          load_ready <= 1'b1;
          if (accept) begin
            ld_addr <= ld_addr + 1'b1;
            if (load_last || ld_addr == LAST_ADDR) begin
              state      <= RUN;
              load_ready <= 1'b0;
              boot_done  <= 1'b1;
              cpu_rst_n  <= 1'b1;
              if (!load_last) load_overflow <= 1'b1;
            end
          end
        end
        RUN: begin
          load_ready <= 1'b0;
          boot_done  <= 1'b1;
          cpu_rst_n  <= 1'b1;
        end
        default: state <= INIT_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_mem.sv
// Directed bench for boot_mem: read responses go through a scoreboard queue
// checked by a monitor; control outputs are checked directly.
module tb_boot_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] pc;
  logic [31:0] instr;
  logic [10:0] ram_addr2;
  logic [31:0] ram_in2;
  logic        mem_w_en;
  logic [31:0] ram_data2;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        cpu_rst_n;
  logic        boot_done;
  logic        load_overflow;

`ifdef BOOT_MEM_CLEAR_EN
  localparam int          EXP_WAIT = 2048;
  localparam logic [10:0] ADDR_B   = 11'd5;
  localparam logic [31:0] EXP_B    = 32'h0;
  localparam logic [31:0] EXP_A3   = 32'h0;
`else
  localparam int          EXP_WAIT = 1;
  localparam logic [10:0] ADDR_B   = 11'd0;
  localparam logic [31:0] EXP_B    = 32'hE3A0_0001;
  localparam logic [31:0] EXP_A3   = 32'hA000_0003;
`endif

  typedef struct {
    logic [31:0] exp_instr;
    logic [31:0] exp_data;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   n_compared = 0;
  int   n_mismatched = 0;
  int   next_tag = 0;
  logic req = 1'b0;
  logic rsp_due = 1'b0;

  boot_mem dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr),
    .ram_addr2(ram_addr2), .ram_in2(ram_in2), .mem_w_en(mem_w_en),
    .ram_data2(ram_data2), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .cpu_rst_n(cpu_rst_n),
    .boot_done(boot_done), .load_overflow(load_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  always @(posedge clk) rsp_due <= req;

  // A read issued before an edge produces its response right after that edge.
  always @(negedge clk) begin
    if (rsp_due) begin
      if (sb.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL scoreboard_empty: response with no expected entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_compared += 2;
        if (instr !== e.exp_instr) begin
          n_mismatched++;
          $display("[TB] FAIL read%0d_instr: got %h expected %h", e.tag, instr, e.exp_instr);
        end
        if (ram_data2 !== e.exp_data) begin
          n_mismatched++;
          $display("[TB] FAIL read%0d_data2: got %h expected %h", e.tag, ram_data2, e.exp_data);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic issue_read(input logic [10:0] p, input logic [10:0] a,
                            input logic [31:0] ei, input logic [31:0] ed);
    exp_t e;
    pc        = p;
    ram_addr2 = a;
    e.exp_instr = ei;
    e.exp_data  = ed;
    e.tag       = next_tag++;
    sb.push_back(e);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [31:0] d, input logic l);
    int n = 0;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = l;
    while (!load_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!load_ready) check_output("send_ready_timeout", {31'b0, load_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!load_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 32'(n), 32'(EXP_WAIT));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    check_output("rst_load_ready", {31'b0, load_ready}, 32'd0);
    check_output("rst_boot_done", {31'b0, boot_done}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc = '0; ram_addr2 = '0; ram_in2 = '0; mem_w_en = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;

    repeat (3) @(negedge clk);
    check_output("reset_instr", instr, 32'h0);
    check_output("reset_data2", ram_data2, 32'h0);
    check_output("reset_load_ready", {31'b0, load_ready}, 32'd0);
    check_output("reset_boot_done", {31'b0, boot_done}, 32'd0);
    check_output("reset_overflow", {31'b0, load_overflow}, 32'd0);
    check_output("reset_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
    rst = 1'b0;
    wait_ready("first_ready_latency");

    apply_stimulus(32'hE3A0_0001, 1'b1);
    load_valid = 1'b0; load_last = 1'b0;
    check_output("single_boot_done", {31'b0, boot_done}, 32'd1);
    issue_read(11'd0, ADDR_B, 32'hE3A0_0001, EXP_B);

    ram_addr2 = 11'd7; ram_in2 = 32'hAAAA; mem_w_en = 1'b1;
    @(negedge clk);
    ram_in2 = 32'hBBBB;
    issue_read(11'd7, 11'd7, 32'hAAAA, 32'hAAAA);
    mem_w_en = 1'b0;
    issue_read(11'd7, 11'd7, 32'hBBBB, 32'hBBBB);

    pulse_reset();
    wait_ready("ovf_ready_latency");
    for (int i = 0; i < 2047; i++) apply_stimulus(32'hA000_0000 + 32'(i), 1'b0);
    check_output("pre_ovf_flag", {31'b0, load_overflow}, 32'd0);
    check_output("pre_ovf_boot_done", {31'b0, boot_done}, 32'd0);
    apply_stimulus(32'hA000_07FF, 1'b0);
    load_valid = 1'b0;
    check_output("ovf_flag", {31'b0, load_overflow}, 32'd1);
    check_output("ovf_boot_done", {31'b0, boot_done}, 32'd1);
    check_output("ovf_load_ready", {31'b0, load_ready}, 32'd0);
    issue_read(11'd2047, 11'd0, 32'hA000_07FF, 32'hA000_0000);

    pulse_reset();
    wait_ready("reload_ready_latency");
    load_last = 1'b1;
    @(negedge clk);
    @(negedge clk);
    load_last = 1'b0;
    check_output("last_no_valid_boot_done", {31'b0, boot_done}, 32'd0);
    mem_w_en = 1'b1; ram_in2 = 32'hDEAD;
    issue_read(11'd3, 11'd3, 32'h0, 32'h0);
    mem_w_en = 1'b0;
    apply_stimulus(32'h55, 1'b0);
    apply_stimulus(32'h66, 1'b0);
    load_valid = 1'b0;
    pulse_reset();
    wait_ready("midload_ready_latency");
    check_output("midload_boot_done", {31'b0, boot_done}, 32'd0);

    apply_stimulus(32'h11, 1'b0);
    apply_stimulus(32'h22, 1'b0);
    check_output("burst_cpu_rst_n_low", {31'b0, cpu_rst_n}, 32'd0);
    apply_stimulus(32'h33, 1'b1);
    load_valid = 1'b0; load_last = 1'b0;
    check_output("burst_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd1);
    check_output("burst_boot_done", {31'b0, boot_done}, 32'd1);
    check_output("burst_load_ready", {31'b0, load_ready}, 32'd0);
    check_output("burst_overflow", {31'b0, load_overflow}, 32'd0);
    issue_read(11'd0, 11'd3, 32'h11, EXP_A3);
    issue_read(11'd1, 11'd1, 32'h22, 32'h22);
    issue_read(11'd2, 11'd2, 32'h33, 32'h33);

    repeat (2) @(negedge clk);
    check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
